// File: rtl/cart_bus_pkg.sv
// Shared definitions for the cartridge-bus host.
// Holds the bus-cycle state enum, the address-region boundaries used by the
// decoder, and the base of the mapper bank registers.
package cart_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } bus_state_t;

    // Byte-address region boundaries
    localparam logic [23:0] ROM_END  = 24'h40_0000;
    localparam logic [23:0] CAS_END  = 24'hE0_0000;
    localparam logic [15:0] TME_PAGE = 16'hA130;

    // First mapper bank register; banks sit on odd bytes up to $A130FF
    localparam logic [23:0] BANK_REG_BASE = 24'hA1_30F1;

endpackage

// File: rtl/cart_addr_decode.sv
// Combinational region decode of a cartridge word address.
//   addr    : byte address bits [23:1]
//   rom_sel : address below $400000 (drives /CE_0)
//   tme_sel : address in page $A130xx (drives /TIME)
//   cas_rgn : address below $E00000 (read strobe /CAS0 may fire)
module cart_addr_decode
    import cart_bus_pkg::*;
(
    input  logic [22:0] addr,
    output logic        rom_sel,
    output logic        tme_sel,
    output logic        cas_rgn
);

    assign rom_sel = {addr, 1'b0} < ROM_END;
    assign tme_sel = addr[22:7] == TME_PAGE;
    assign cas_rgn = {addr, 1'b0} < CAS_END;

endmodule

// File: rtl/cart_bus_host.sv
// Mega Drive cartridge-bus initiator. Converts one read/write command at a
// time into a setup / strobe / hold bus cycle followed by a one-cycle
// response pulse.
//   clk, rst_n        : clock, synchronous active-low reset
//   cmd_*             : command handshake (write flag, word address, data)
//   rsp_valid/rsp_data: completion pulse and last captured read word
//   cart_*            : cartridge address, split data bus and output enable
//   ce_0, cas0, lwr, tme : active-low bus strobes
// Every bus output is a flop fed from next-state values, so strobes are
// glitch-free and line up exactly with the state they belong to.
module cart_bus_host
    import cart_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 2,   // >= 1
    parameter int STROBE_CYC = 3,   // >= 1
    parameter int HOLD_CYC   = 1    // >= 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [22:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [22:0] cart_address,
    input  logic [15:0] cart_data_in,
    output logic [15:0] cart_data_out,
    output logic        cart_data_oe,
    output logic        ce_0,
    output logic        cas0,
    output logic        lwr,
    output logic        tme
);

    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    bus_state_t       state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             accept;
    logic [22:0]      addr_q, addr_nx;
    logic             write_q, write_nx;
    logic [15:0]      wdata_q;
    logic             rom_sel, tme_sel, cas_rgn;
    logic             in_bus_nx, strobe_nx;

    // Phase sequencer: one down-counter reloaded with (length - 1) on entry
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_SETUP;
                    cnt_nx   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_nx = ST_STROBE;
                    cnt_nx   = STROBE_LD;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_nx = ST_RESP;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Decode the address that will be on the bus next cycle, so the
    // registered chip enables come up together with the address itself.
    assign addr_nx  = accept ? cmd_addr  : addr_q;
    assign write_nx = accept ? cmd_write : write_q;

    cart_addr_decode u_decode (
        .addr    (addr_nx),
        .rom_sel (rom_sel),
        .tme_sel (tme_sel),
        .cas_rgn (cas_rgn)
    );

    assign in_bus_nx = (state_nx == ST_SETUP) || (state_nx == ST_STROBE) ||
                       (state_nx == ST_HOLD);
    assign strobe_nx = (state_nx == ST_STROBE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            cart_data_oe <= 1'b0;
            ce_0         <= 1'b1;
            cas0         <= 1'b1;
            lwr          <= 1'b1;
            tme          <= 1'b1;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            if (accept) begin
                addr_q  <= cmd_addr;
                write_q <= cmd_write;
                wdata_q <= cmd_wdata;
            end
            cmd_ready    <= (state_nx == ST_IDLE);
            rsp_valid    <= (state_nx == ST_RESP);
            ce_0         <= ~(in_bus_nx & rom_sel);
            tme          <= ~(in_bus_nx & tme_sel);
            cart_data_oe <= in_bus_nx & write_nx;
            // Writes keep /CAS0 high so the mapper sees a register write
            cas0         <= ~(strobe_nx & ~write_nx & cas_rgn);
            lwr          <= ~(strobe_nx & write_nx);
            // Sample read data on the edge closing the final strobe cycle
            if (state_q == ST_STROBE && cnt_q == '0 && !write_q)
                rsp_data <= cart_data_in;
        end
    end

    assign cart_address  = addr_q;
    assign cart_data_out = wdata_q;

endmodule

// File: tb/tb_cart_bus_host.sv
// Bench for cart_bus_host: default-timing DUT with a cart/mapper model and
// a response scoreboard, plus a 1/1/1-timing DUT for back-to-back reads.
module tb_cart_bus_host;
    import cart_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write, rsp_valid;
    logic [22:0] cmd_addr, cart_address;
    logic [15:0] cmd_wdata, rsp_data, cart_data_in, cart_data_out;
    logic        cart_data_oe, ce_0, cas0, lwr, tme;

    cart_bus_host dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .cart_address(cart_address), .cart_data_in(cart_data_in),
        .cart_data_out(cart_data_out), .cart_data_oe(cart_data_oe),
        .ce_0(ce_0), .cas0(cas0), .lwr(lwr), .tme(tme)
    );

    logic        cmd_valid_f, cmd_ready_f, rsp_valid_f;
    logic [22:0] cmd_addr_f, cart_address_f;
    logic [15:0] rsp_data_f, cart_data_in_f, cart_data_out_f;
    logic        cart_data_oe_f, ce_0_f, cas0_f, lwr_f, tme_f;

    cart_bus_host #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_f), .cmd_ready(cmd_ready_f), .cmd_write(1'b0),
        .cmd_addr(cmd_addr_f), .cmd_wdata(16'h0000),
        .rsp_valid(rsp_valid_f), .rsp_data(rsp_data_f),
        .cart_address(cart_address_f), .cart_data_in(cart_data_in_f),
        .cart_data_out(cart_data_out_f), .cart_data_oe(cart_data_oe_f),
        .ce_0(ce_0_f), .cas0(cas0_f), .lwr(lwr_f), .tme(tme_f)
    );

    assign cart_data_in_f = !cas0_f ? (cart_address_f[15:0] ^ 16'h5A5A) : 16'hFFFF;

    // ---------------- cart + mapper model ----------------
    logic        m_rom, m_tme, m_cas;
    logic [23:0] cart_byte;
    logic [7:0]  bank [8];

    cart_addr_decode u_mdec (.addr(cart_address), .rom_sel(m_rom), .tme_sel(m_tme), .cas_rgn(m_cas));
    assign cart_byte = {cart_address, 1'b0};

    initial for (int i = 0; i < 8; i++) bank[i] = 8'(i);

    // Register write: /LWR low, /TIME low, /CE_0 and /CAS0 high, $A130F1..FF
    always @(posedge clk)
        if (!lwr && !tme && ce_0 && cas0 && m_tme && cart_byte[7:4] == 4'hF)
            bank[cart_address[2:0]] <= cart_data_out[7:0];

    always_comb begin
        cart_data_in = 16'hFFFF;
        if (!cas0 && !ce_0 && m_rom)
            cart_data_in = (cart_byte == 24'h00_0100) ? 16'h4E71
                                                      : {bank[cart_byte[21:19]], cart_byte[7:0]};
        else if (!cas0 && m_cas)
            cart_data_in = {8'hC0, cart_byte[7:0]};
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest pushed value
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else begin
                chk("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command and record cycles T+1..T+10 (bit k = cycle T+k)
    task automatic run_cmd(input logic wr, input logic [23:0] baddr, input logic [15:0] wd,
                           input logic [15:0] exp,
                           output logic [10:1] ce_v, output logic [10:1] cas_v,
                           output logic [10:1] lwr_v, output logic [10:1] tme_v,
                           output logic [10:1] oe_v, output logic [10:1] rv_v,
                           output logic [10:1] rdy_v, output logic [15:0] dout4);
        wait_ready();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = baddr[23:1]; cmd_wdata = wd;
        sb.push_back(exp);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        dout4 = 16'h0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            ce_v[k] = ce_0; cas_v[k] = cas0; lwr_v[k] = lwr; tme_v[k] = tme;
            oe_v[k] = cart_data_oe; rv_v[k] = rsp_valid; rdy_v[k] = cmd_ready;
            if (k == 4) dout4 = cart_data_out;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic [10:1] ce, cas, lwr, tme;
    } vec_t;

    localparam logic [10:1] C_LO = 10'b1111000000;  // low T+1..T+6
    localparam logic [10:1] S_LO = 10'b1111100011;  // low T+3..T+5
    localparam logic [10:1] HI   = 10'b1111111111;
    localparam logic [10:1] RV   = 10'b0001000000;
    localparam logic [10:1] RDY  = 10'b1110000000;
    localparam logic [10:1] OE   = 10'b0000111111;

    initial begin
        vec_t vecs [9];
        logic [10:1] ce_v, cas_v, lwr_v, tme_v, oe_v, rv_v, rdy_v;
        logic [15:0] dout4;
        logic        seen;

        vecs[0] = '{1'b0, 24'h00_0100, 16'h0000, 16'h4E71, C_LO, S_LO, HI,   HI};
        vecs[1] = '{1'b1, 24'hA1_30F3, 16'h0005, 16'h4E71, HI,   HI,   S_LO, C_LO};
        vecs[2] = '{1'b0, 24'h08_0000, 16'h0000, 16'h0500, C_LO, S_LO, HI,   HI};
        vecs[3] = '{1'b1, 24'hA1_30FF, 16'h1234, 16'h0500, HI,   HI,   S_LO, C_LO};
        vecs[4] = '{1'b0, 24'h38_00A0, 16'h0000, 16'h34A0, C_LO, S_LO, HI,   HI};
        vecs[5] = '{1'b0, 24'hA1_3002, 16'h0000, 16'hC002, HI,   S_LO, HI,   C_LO};
        vecs[6] = '{1'b0, 24'hE0_0010, 16'h0000, 16'hFFFF, HI,   HI,   HI,   HI};
        vecs[7] = '{1'b1, 24'h00_0200, 16'h00AA, 16'hFFFF, C_LO, HI,   S_LO, HI};
        vecs[8] = '{1'b0, 24'h00_0102, 16'h0000, 16'h0002, C_LO, S_LO, HI,   HI};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_valid_f = 1'b0; cmd_addr_f = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_address", 32'(cart_address), 32'h0);
        chk("rst_data_out", 32'(cart_data_out), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", 32'({ce_0, cas0, lwr, tme, cmd_ready, cart_data_oe, rsp_valid}),
                32'(7'b1111100));
        end

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data,
                    ce_v, cas_v, lwr_v, tme_v, oe_v, rv_v, rdy_v, dout4);
            chk($sformatf("v%0d_ce_0", i), 32'(ce_v), 32'(vecs[i].ce));
            chk($sformatf("v%0d_cas0", i), 32'(cas_v), 32'(vecs[i].cas));
            chk($sformatf("v%0d_lwr", i), 32'(lwr_v), 32'(vecs[i].lwr));
            chk($sformatf("v%0d_tme", i), 32'(tme_v), 32'(vecs[i].tme));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rv_v), 32'(RV));
            chk($sformatf("v%0d_cmd_ready", i), 32'(rdy_v), 32'(RDY));
            chk($sformatf("v%0d_oe", i), 32'(oe_v), vecs[i].wr ? 32'(OE) : 32'h0);
            if (vecs[i].wr) chk($sformatf("v%0d_data_out", i), 32'(dout4), 32'(vecs[i].wdata));
            if (i == 1) chk("bank1", 32'(bank[1]), 32'h05);
            if (i == 3) chk("bank7", 32'(bank[7]), 32'h34);
        end

        // Reset during the STROBE phase of a read aborts it without a response
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 23'h00_0080;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_strobe", 32'(cas0), 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_strobes", 32'({ce_0, cas0, lwr, tme, cart_data_oe, cmd_ready, rsp_valid}),
            32'(7'b1111010));
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= rsp_valid; end
        chk("abort_no_rsp", 32'(seen), 32'h0);
        run_cmd(1'b0, 24'h00_0100, 16'h0, 16'h4E71, ce_v, cas_v, lwr_v, tme_v, oe_v, rv_v, rdy_v, dout4);
        chk("post_abort_ce_0", 32'(ce_v), 32'(C_LO));
        chk("post_abort_rsp_valid", 32'(rv_v), 32'(RV));

        // Minimum timing, back-to-back: $3FFFFE then $400000 with cmd_valid held
        @(negedge clk);
        cmd_valid_f = 1'b1; cmd_addr_f = 23'h1F_FFFF;
        @(posedge clk);
        #1 cmd_addr_f = 23'h20_0000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            ce_v[k] = ce_0_f; rv_v[k] = rsp_valid_f; rdy_v[k] = cmd_ready_f;
            if (k == 4) chk("fast_rsp0", 32'(rsp_data_f), 32'hA5A5);
            if (k == 9) chk("fast_rsp1", 32'(rsp_data_f), 32'h5A5A);
            if (k == 5) begin
                @(posedge clk);
                #1 cmd_valid_f = 1'b0;
            end
        end
        chk("fast_ce_0", 32'(ce_v), 32'(10'b1111111000));
        chk("fast_rsp_valid", 32'(rv_v), 32'(10'b0100001000));
        chk("fast_cmd_ready", 32'(rdy_v), 32'(10'b1000010000));

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
